// File: rtl/reg_readback_pkg.sv
// Shared types, default sizes and the request length check for the readback engine.
package reg_readback_pkg;

  localparam int unsigned DefNRegs = 16;
  localparam int unsigned DefRegW  = 8;
  localparam int unsigned DefAddrW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // A run must cover at least one register and no more than the whole bank.
  function automatic logic len_legal(input int unsigned len, input int unsigned n_regs);
    return (len != 0) && (len <= n_regs);
  endfunction

endpackage

// File: rtl/reg_readback_if.sv
// Request handshake and serial stream between the readback engine and its consumer.
interface reg_readback_if
  import reg_readback_pkg::*;
#(
  parameter int unsigned AddrW = DefAddrW
);

  logic             rd_req;
  logic [AddrW-1:0] rd_addr;
  logic [AddrW:0]   rd_len;
  logic             rd_ack;
  logic             rd_err;
  logic             busy;
  logic             sdo;
  logic             sdo_valid;
  logic             sdo_ready;
  logic             sdo_last;
  logic             done;

  // Requester / stream consumer side.
  modport master (
    output rd_req, rd_addr, rd_len, sdo_ready,
    input  rd_ack, rd_err, busy, sdo, sdo_valid, sdo_last, done
  );

  // Readback engine side.
  modport slave (
    input  rd_req, rd_addr, rd_len, sdo_ready,
    output rd_ack, rd_err, busy, sdo, sdo_valid, sdo_last, done
  );

endinterface

// File: rtl/reg_readback_piso.sv
// Parallel-in/serial-out shifter: load a register word, shift left, present the MSB.
module readback_piso #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [Width-1:0] data_i,
  output logic             msb_o
);

  logic [Width-1:0] sr_q, sr_d;

  // Load has priority over shift; otherwise hold.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = sr_q << 1;
    end
  end

  // Shift register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb_o = sr_q[Width-1];

endmodule

// File: rtl/reg_readback.sv
// Serial readback engine: snapshot the register bank on request, then stream a
// contiguous (wrapping) run of registers MSB-first over a valid/ready bit port.
module reg_readback
  import reg_readback_pkg::*;
#(
  parameter int unsigned NRegs = DefNRegs,
  parameter int unsigned RegW  = DefRegW,
  parameter int unsigned AddrW = DefAddrW
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [NRegs*RegW-1:0] bank_q_i,
  reg_readback_if.slave         rb_io
);

  localparam int unsigned CntW = (RegW > 1) ? $clog2(RegW) : 1;
  localparam logic [CntW-1:0] BitTop = CntW'(RegW - 1);

  state_e                  state_q, state_d;
  logic [NRegs*RegW-1:0]   snap_q, snap_d;
  logic [AddrW-1:0]        ptr_q, ptr_d, ptr_inc;
  logic [CntW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [AddrW-1:0]        regs_left_q, regs_left_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    last_q, last_d;
  logic                    xfer;
  logic                    piso_load, piso_shift, piso_msb;
  logic [RegW-1:0]         piso_data;

  // Next-state, counter and shifter-control logic.
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    ptr_d       = ptr_q;
    bit_cnt_d   = bit_cnt_q;
    regs_left_d = regs_left_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    piso_load   = 1'b0;
    piso_shift  = 1'b0;
    ptr_inc     = ptr_q + 1'b1;  // natural wrap: NRegs is a power of two
    piso_data   = snap_q[ptr_inc*RegW +: RegW];
    xfer        = (state_q == StShift) && rb_io.sdo_ready;

    unique case (state_q)
      StIdle: begin
        if (rb_io.rd_req) begin
          if (len_legal(32'(rb_io.rd_len), NRegs)) begin
            snap_d      = bank_q_i;
            ptr_d       = rb_io.rd_addr;
            bit_cnt_d   = BitTop;
            regs_left_d = AddrW'(rb_io.rd_len - 1'b1);
            ack_d       = 1'b1;
            piso_load   = 1'b1;
            // Snapshot is being written this edge, so feed the shifter from the live bank.
            piso_data   = bank_q_i[rb_io.rd_addr*RegW +: RegW];
            state_d     = StShift;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StShift: begin
        if (xfer) begin
          if (bit_cnt_q != '0) begin
            bit_cnt_d  = bit_cnt_q - 1'b1;
            piso_shift = 1'b1;
          end else if (regs_left_q != '0) begin
            ptr_d       = ptr_inc;
            bit_cnt_d   = BitTop;
            regs_left_d = regs_left_q - 1'b1;
            piso_load   = 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    last_d = (state_d == StShift) && (bit_cnt_d == '0) && (regs_left_d == '0);
  end

  // State, counters, snapshot and registered pulses.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      snap_q      <= '0;
      ptr_q       <= '0;
      bit_cnt_q   <= '0;
      regs_left_q <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      ptr_q       <= ptr_d;
      bit_cnt_q   <= bit_cnt_d;
      regs_left_q <= regs_left_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      last_q      <= last_d;
    end
  end

  readback_piso #(
    .Width (RegW)
  ) u_piso (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (piso_load),
    .shift_i (piso_shift),
    .data_i  (piso_data),
    .msb_o   (piso_msb)
  );

  // All outputs come straight from flops; sdo is masked so it idles low.
  assign rb_io.rd_ack    = ack_q;
  assign rb_io.rd_err    = err_q;
  assign rb_io.busy      = (state_q == StShift);
  assign rb_io.sdo_valid = (state_q == StShift);
  assign rb_io.sdo       = piso_msb & (state_q == StShift);
  assign rb_io.sdo_last  = last_q;
  assign rb_io.done      = (state_q == StDone);

endmodule

// File: tb/tb_reg_readback.sv
// Self-checking bench for reg_readback: queue-based bit-stream model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_reg_readback;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] bank = '0;

  int checks = 0;
  int errors = 0;
  int n;

  reg_readback_if #(.AddrW(4)) rb ();

  reg_readback #(
    .NRegs (16),
    .RegW  (8),
    .AddrW (4)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .bank_q_i (bank),
    .rb_io    (rb)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit m_busy = 0, m_done = 0, m_ack = 0, m_err = 0;
  bit exp_q[$];
  bit log_q[$];

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_ack = 0; m_err = 0;
      exp_q.delete();
    end else begin
      m_ack = 0; m_err = 0;
      if (m_busy) begin
        if (rb.sdo_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end else if (m_done) begin
        m_done = 0;
      end else if (rb.rd_req) begin
        if (rb.rd_len >= 1 && rb.rd_len <= 16) begin
          for (int k = 0; k < int'(rb.rd_len); k++) begin
            int r;
            r = (int'(rb.rd_addr) + k) % 16;
            for (int b = 7; b >= 0; b--) exp_q.push_back(bank[r*8 + b]);
          end
          m_busy = 1;
          m_ack  = 1;
        end else begin
          m_err = 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model each cycle; log accepted bits.
  always @(negedge clk) begin
    check("rd_ack", rb.rd_ack, m_ack);
    check("rd_err", rb.rd_err, m_err);
    check("busy", rb.busy, m_busy);
    check("sdo_valid", rb.sdo_valid, m_busy);
    check("sdo", rb.sdo, (m_busy && exp_q.size() > 0) ? exp_q[0] : 1'b0);
    check("sdo_last", rb.sdo_last, m_busy && exp_q.size() == 1);
    check("done", rb.done, m_done);
    if (!reset && rb.sdo_valid && rb.sdo_ready) log_q.push_back(rb.sdo);
  end

  // ---------------- helpers ----------------
  function automatic logic [63:0] pack_log(input int first, input int cnt);
    logic [63:0] v;
    v = '0;
    for (int i = first; i < first + cnt && i < log_q.size(); i++) v = {v[62:0], log_q[i]};
    return v;
  endfunction

  task automatic set_reg(input int idx, input logic [7:0] v);
    bank[idx*8 +: 8] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] addr, input logic [4:0] len);
    rb.rd_addr = addr;
    rb.rd_len  = len;
    rb.rd_req  = 1'b1;
    step();
    rb.rd_req  = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cnt);
    cnt = 0;
    while (rb.done !== 1'b1 && cnt < budget) begin
      step();
      cnt++;
    end
    if (rb.done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_done: no done within %0d cycles", budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rb.rd_req = 0; rb.rd_addr = 0; rb.rd_len = 0; rb.sdo_ready = 1;
    step();
    check("reset_outputs",
          {rb.rd_ack, rb.rd_err, rb.busy, rb.sdo, rb.sdo_valid, rb.sdo_last, rb.done}, 0);
    step();
    reset = 0;
    step();

    // Single read of 0xA5
    set_reg(3, 8'hA5);
    log_q.delete();
    issue(4'd3, 5'd1);
    check("t1_ack", rb.rd_ack, 1);
    check("t1_busy", rb.busy, 1);
    check("t1_first_bit", rb.sdo, 1);
    wait_done(40, n);
    check("t1_done_latency", n, 8);
    check("t1_count", log_q.size(), 8);
    check("t1_data", pack_log(0, 8), 64'hA5);
    // Request held through the done cycle is taken only on the following cycle
    rb.rd_addr = 3; rb.rd_len = 1; rb.rd_req = 1;
    step();
    check("t1_no_ack_from_done", rb.rd_ack, 0);
    step();
    rb.rd_req = 0;
    check("t1_ack_after_done", rb.rd_ack, 1);
    wait_done(40, n);
    step();

    // Wrap-around 15 -> 0
    set_reg(15, 8'hFF);
    set_reg(0, 8'h00);
    log_q.delete();
    issue(4'd15, 5'd2);
    wait_done(60, n);
    check("t2_count", log_q.size(), 16);
    check("t2_data", pack_log(0, 16), 64'hFF00);
    step();

    // Backpressure with bank overwritten after acceptance
    set_reg(6, 8'h3C); set_reg(7, 8'h81); set_reg(8, 8'h7E);
    log_q.delete();
    issue(4'd6, 5'd3);
    bank = ~bank;
    n = 0;
    while (rb.done !== 1'b1 && n < 400) begin
      rb.sdo_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    rb.sdo_ready = 1;
    check("t3_done_seen", rb.done, 1);
    check("t3_count", log_q.size(), 24);
    check("t3_data", pack_log(0, 24), 64'h3C817E);
    step();

    // Illegal lengths
    issue(4'd2, 5'd0);
    check("t4_err_len0", rb.rd_err, 1);
    check("t4_busy_len0", rb.busy, 0);
    issue(4'd2, 5'd17);
    check("t4_err_len17", rb.rd_err, 1);
    check("t4_ack_len17", rb.rd_ack, 0);
    step();

    // Request during a run is ignored
    set_reg(1, 8'h5A); set_reg(2, 8'hC3); set_reg(9, 8'hEE);
    log_q.delete();
    issue(4'd1, 5'd2);
    repeat (3) step();
    rb.rd_addr = 9; rb.rd_len = 1; rb.rd_req = 1;
    repeat (5) begin
      step();
      check("t4_no_ack_busy", rb.rd_ack, 0);
    end
    rb.rd_req = 0;
    wait_done(60, n);
    check("t4_count", log_q.size(), 16);
    check("t4_data", pack_log(0, 16), 64'h5AC3);
    step();

    // Full bank from address 5
    for (int i = 0; i < 16; i++) set_reg(i, {4'(i), 4'(15 - i)});
    log_q.delete();
    issue(4'd5, 5'd16);
    wait_done(300, n);
    check("t5_count", log_q.size(), 128);
    for (int k = 0; k < 16; k++) begin
      int r;
      r = (5 + k) % 16;
      check("t5_byte", pack_log(k*8, 8), {56'h0, 4'(r), 4'(15 - r)});
    end
    step();

    // Reset in the middle of a run, then a fresh request
    issue(4'd0, 5'd4);
    repeat (19) step();
    check("t6_mid_busy", rb.busy, 1);
    reset = 1;
    step();
    check("t6_reset_outputs",
          {rb.rd_ack, rb.rd_err, rb.busy, rb.sdo, rb.sdo_valid, rb.sdo_last, rb.done}, 0);
    reset = 0;
    step();
    check("t6_no_done", rb.done, 0);
    set_reg(2, 8'h96);
    log_q.delete();
    issue(4'd2, 5'd1);
    check("t6_ack", rb.rd_ack, 1);
    wait_done(40, n);
    check("t6_data", pack_log(0, 8), 64'h96);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_readback.md
# reg_readback

Serial readback engine for the configuration register bank. It is the read-side counterpart of the per-bit write-enabled configuration registers. On a read request it snapshots the whole bank, then streams a contiguous run of registers (start address, length, wrap-around) out MSB-first over a 1-bit valid/ready serial port toward the chip's test/debug interface.

## Interface
Parameters:
- N_REGS, 16, registers in the bank (power of two)
- REG_W, 8, bits per register
- ADDR_W, 4, register address width, equal to log2(N_REGS)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- bank_q  in  N_REGS*REG_W  live register contents; reg i occupies bits [i*REG_W +: REG_W]
- rd_req  in  1  read request, level-sampled in IDLE
- rd_addr  in  ADDR_W  first register to read
- rd_len  in  ADDR_W+1  number of registers, legal 1..N_REGS
- rd_ack  out  1  one-cycle pulse: request accepted
- rd_err  out  1  one-cycle pulse: request rejected (rd_len==0 or rd_len>N_REGS)
- busy  out  1  high from acceptance until the final bit transfers
- sdo  out  1  serial data
- sdo_valid  out  1  sdo holds a valid bit
- sdo_ready  in  1  consumer accepts bit when high with sdo_valid
- sdo_last  out  1  marks the final bit of the run
- done  out  1  one-cycle pulse after the final transfer

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, rd_req=1, legal rd_len:
  - Capture all of bank_q into the snapshot.
  - Load reg_ptr=rd_addr, bit_cnt=REG_W-1, regs_left=rd_len-1.
  - Pulse rd_ack, go to SHIFT.
- IDLE, rd_req=1, illegal rd_len: pulse rd_err, stay in IDLE, no snapshot.
- SHIFT:
  - sdo = snapshot[reg_ptr][bit_cnt], MSB first. sdo_valid=1.
  - A transfer is sdo_valid && sdo_ready.
  - On a transfer with bit_cnt>0: decrement bit_cnt.
  - On a transfer with bit_cnt==0 and regs_left>0: reg_ptr=(reg_ptr+1) mod N_REGS (wraps N_REGS-1 to 0), bit_cnt=REG_W-1, decrement regs_left.
  - sdo_last=1 when bit_cnt==0 && regs_left==0.
  - A transfer with sdo_last=1 goes to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- rd_req in SHIFT or DONE is ignored: no ack, no err, not queued.
- bank_q changes after capture do not affect the streamed data.
- sdo_ready low stalls: sdo, sdo_valid, sdo_last and all counters hold.
- Total transfers per accepted request = rd_len*REG_W.

## Timing
- Reset values: rd_ack, rd_err, busy, sdo, sdo_valid, sdo_last, done all 0; state IDLE; counters and snapshot 0.
- Reset asserted mid-run aborts the run: outputs at reset values from the next edge, no done pulse.
- Request sampled at edge t → rd_ack, busy, sdo_valid and the first bit all high at t+1 (1-cycle latency).
- With sdo_ready held high, one bit per cycle; the final bit is on cycle t+rd_len*REG_W and done is on the following cycle.
- Earliest next acceptance is rd_req sampled in the cycle after done; sdo_valid is low in the DONE cycle.
- sdo_valid never drops mid-run without reset. Outputs are registered; there is no combinational path from sdo_ready to sdo_valid.

## Structure
- Shared package reg_readback_pkg: state enum (IDLE, SHIFT, DONE), default N_REGS/REG_W/ADDR_W constants, and a function for the legal-length check.
- One sub-module, readback_piso: a REG_W-bit parallel-in/serial-out shifter with load, shift-enable and MSB output, fed from the snapshot mux at reg_ptr.
- FSM, counters and snapshot stay in the top module.

## Test plan
- Single read: bank reg3=0xA5, rd_addr=3, rd_len=1, sdo_ready=1 → rd_ack at t+1; sdo 1,0,1,0,0,1,0,1; sdo_last on the 8th bit; done the next cycle.
- Wrap-around: rd_addr=15, rd_len=2, reg15=0xFF, reg0=0x00 → 8 ones then 8 zeros; 16 transfers total.
- Backpressure plus snapshot: toggle sdo_ready pseudo-randomly and overwrite bank_q after rd_ack → stream equals the values captured at acceptance; outputs hold during stalls.
- Illegal and overlapping requests: rd_len=0 → rd_err pulse, no busy. rd_req during SHIFT → no rd_ack, no rd_err, and the current stream is unaffected.
- Full bank and reset: rd_len=16 from addr 5 gives 128 bits in order 5..15, 0..4. Separately, assert reset at bit 20 of a run → next cycle all outputs are 0, state IDLE; a new request then succeeds.
